ks_subtractor_pipe: RTL and testbench

Pipelined 12-bit Kogge-Stone subtractor computing D = X − Y − BIN. It is the inverse-direction companion to the team's combinational Kogge-Stone adder: it uses the same generate/propagate and carry-operator prefix network on X + ~Y + ~BIN. The tree is split across three register stages, with valid/ready handshakes on both sides. It sits in the datapath wherever a registered, backpressure-aware subtraction is needed.

---
 rtl/ks_subtractor_pipe.sv | 153 +++++++++++++++
 tb/tb_ks_subtractor_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ks_subtractor_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor: d = x - y - bin with valid/ready on both sides.
// Optional KSS_SATURATE_EN: clamp the emitted difference to zero whenever a borrow-out occurs.
module ks_subtractor_pipe #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         bin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] d_o,
  output logic         bout_o,
  output logic         ovf_o,
  output logic         zero_o
);

  localparam int LVL   = $clog2(W);
  localparam int LVL_A = LVL - LVL / 2;

  // One prefix level: (G,P)[i] combines with (G,P)[i-span]
  function automatic logic [2*W-1:0] ks_level(input logic [W-1:0] g,
                                               input logic [W-1:0] p,
                                               input int span);
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    for (int i = 0; i < W; i++) begin
      if (i >= span) begin
        gn[i] = g[i] | (g[i-span] & p[i]);
        pn[i] = p[i] & p[i-span];
      end else begin
        gn[i] = g[i];
        pn[i] = p[i];
      end
    end
    return {gn, pn};
  endfunction

  logic         v1_q, v2_q, v3_q;
  logic [W-1:0] p0_1_q, g0_1_q;
  logic         cin_1_q, xm_1_q, ym_1_q;
  logic [W-1:0] g2_q, p2_q, p0_2_q;
  logic         cin_2_q, xm_2_q, ym_2_q;
  logic [W-1:0] d_q;
  logic         bout_q, ovf_q, zero_q;

  logic         adv1, adv2, adv3, take;
  logic [W-1:0] p0_1_d, g0_1_d;
  logic [W-1:0] g2_d, p2_d;
  logic [W-1:0] g4, p4;
  logic [W:0]   carry;
  logic [W-1:0] draw;
  logic [W-1:0] d_d;
  logic         bout_d, ovf_d, zero_d;

  assign adv3       = out_ready_i | ~v3_q;
  assign adv2       = adv3 | ~v2_q;
  assign adv1       = adv2 | ~v1_q;
  assign in_ready_o = adv1;
  assign take       = in_valid_i & adv1;

  assign p0_1_d = x_i ^ ~y_i;
  assign g0_1_d = x_i & ~y_i;

  always_comb begin
    g2_d = g0_1_q;
    p2_d = p0_1_q;
    for (int l = 0; l < LVL_A; l++) begin
      {g2_d, p2_d} = ks_level(g2_d, p2_d, 1 << l);
    end
  end

  always_comb begin
    g4 = g2_q;
    p4 = p2_q;
    for (int l = LVL_A; l < LVL; l++) begin
      {g4, p4} = ks_level(g4, p4, 1 << l);
    end
    carry[0] = cin_2_q;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = g4[i] | (p4[i] & cin_2_q);
    end
    draw   = p0_2_q ^ carry[W-1:0];
    bout_d = ~carry[W];
    // Overflow only possible when operand signs differ; then the result sign must follow x
    ovf_d  = (xm_2_q != ym_2_q) & (draw[W-1] != xm_2_q);
`ifdef KSS_SATURATE_EN
    d_d    = bout_d ? '0 : draw;
`else
    d_d    = draw;
`endif
    zero_d = (d_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      p0_1_q  <= '0;
      g0_1_q  <= '0;
      cin_1_q <= 1'b0;
      xm_1_q  <= 1'b0;
      ym_1_q  <= 1'b0;
      g2_q    <= '0;
      p2_q    <= '0;
      p0_2_q  <= '0;
      cin_2_q <= 1'b0;
      xm_2_q  <= 1'b0;
      ym_2_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid_i;
      if (take) begin
        p0_1_q  <= p0_1_d;
        g0_1_q  <= g0_1_d;
        cin_1_q <= ~bin_i;
        xm_1_q  <= x_i[W-1];
        ym_1_q  <= y_i[W-1];
      end
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        g2_q    <= g2_d;
        p2_q    <= p2_d;
        p0_2_q  <= p0_1_q;
        cin_2_q <= cin_1_q;
        xm_2_q  <= xm_1_q;
        ym_2_q  <= ym_1_q;
      end
      // Output data only changes when a real beat moves in, so it holds under stall
      if (adv3) v3_q <= v2_q;
      if (adv3 && v2_q) begin
        d_q    <= d_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid_o = v3_q;
  assign d_o         = d_q;
  assign bout_o      = bout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Scoreboard bench for ks_subtractor_pipe: directed vectors, latency, backpressure, mid-flight reset.
module tb_ks_subtractor_pipe;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, bin, out_valid, out_ready;
  logic         bout, ovf, zero;
  logic [W-1:0] x, y, d;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ks_subtractor_pipe #(.W(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x_i(x), .y_i(y), .bin_i(bin),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .d_o(d), .bout_o(bout), .ovf_o(ovf), .zero_o(zero)
  );

  // Expected beat from hand-computed raw difference and flags
  function automatic exp_t mk(input logic [W-1:0] draw, input logic b, input logic o);
    exp_t e;
    e.d = draw;
`ifdef KSS_SATURATE_EN
    if (b) e.d = '0;
`endif
    e.bout = b;
    e.ovf  = o;
    e.zero = (e.d == '0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called aligned at posedge+1; returns aligned at posedge+1 with in_valid still high
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv,
                      input exp_t e, output logic first_rdy);
    int w = 0;
    x = xv; y = yv; bin = bv; in_valid = 1'b1;
    @(negedge clk);
    first_rdy = in_ready;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (in_ready) sb.push_back(e);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: x=%0h never accepted", xv);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stale_output: got d=%0h, expected no beat", d);
      end else begin
        mon_e = sb.pop_front();
        chk("d", d, mon_e.d);
        chk("bout", bout, mon_e.bout);
        chk("ovf", ovf, mon_e.ovf);
        chk("zero", zero, mon_e.zero);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fr;
    int   edges;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Latency on an empty pipe: the accepting edge counts as the first
    send(12'h005, 12'h003, 1'b0, mk(12'h002, 1'b0, 1'b0), fr);
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, 3);
    drain();

    send(12'h000, 12'h001, 1'b0, mk(12'hFFF, 1'b1, 1'b0), fr);
    send(12'h800, 12'h001, 1'b0, mk(12'h7FF, 1'b0, 1'b1), fr);
    send(12'h000, 12'hFFF, 1'b1, mk(12'h000, 1'b1, 1'b0), fr);
    send(12'hABC, 12'h123, 1'b1, mk(12'h998, 1'b0, 1'b0), fr);
    send(12'h7FF, 12'h800, 1'b0, mk(12'hFFF, 1'b1, 1'b1), fr);
    send(12'h123, 12'h123, 1'b0, mk(12'h000, 1'b0, 1'b0), fr);
    send(12'hFFF, 12'hFFF, 1'b1, mk(12'hFFF, 1'b1, 1'b0), fr);
    in_valid = 1'b0;
    drain();

    // Backpressure: three beats fill the pipe, the rest wait for the release
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          send(i[W-1:0], 12'h000, 1'b0, mk(i[W-1:0], 1'b0, 1'b0), fr);
          if (i <= 3) chk("bp_accept_immediate", fr, 1);
          if (i == 4) chk("bp_full_in_ready", fr, 0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_no_gap", out_valid, 1);
        end
      end
    join
    drain();

    // Reset with two beats in flight plus one presented during reset
    out_ready = 1'b0;
    send(12'h00A, 12'h001, 1'b0, mk(12'h009, 1'b0, 1'b0), fr);
    send(12'h00B, 12'h001, 1'b0, mk(12'h00A, 1'b0, 1'b0), fr);
    x = 12'h0FF; y = 12'h001; bin = 1'b0; in_valid = 1'b1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstmid_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(12'h010, 12'h004, 1'b1, mk(12'h00B, 1'b0, 1'b0), fr);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
